thread_sched: RTL and testbench

Round-robin scheduler that decides which thread the engine's block-building datapath (procb record fetch, memory read, realign/pad, core input) serves next. It tracks per-thread "has work" requests against per-thread core input-slot readiness and issues one grant at a time. It holds off the next grant until the datapath reports the block sent, and it flags protocol violations and hangs. It sits between thread-state/procb bookkeeping and the process_bytes sequencer.

---
 rtl/thread_sched.sv | 127 ++++++++++++
 tb/tb_thread_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_sched.sv
// Round-robin thread grant scheduler: offers one thread at a time, holds off until done/abort/timeout.
// Latency: elig -> grant_valid in 2 edges; offer held until grant_ack; all outputs registered.
module thread_sched #(
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
  parameter int TIMEOUT       = 1023
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [N_THREADS-1:0]     req,
  input  logic [N_THREADS-1:0]     slot_ready,
  output logic                     grant_valid,
  output logic [N_THREADS_MSB:0]   grant_num,
  input  logic                     grant_ack,
  input  logic                     done,
  input  logic [N_THREADS_MSB:0]   done_num,
  input  logic                     abort,
  output logic                     busy,
  output logic [2:0]               err
);

  localparam int GW = N_THREADS_MSB + 1;
  localparam int PW = N_THREADS_MSB + 2;
  localparam logic [GW-1:0] PTR_RST = GW'(N_THREADS - 1);
  localparam logic [15:0]   TMAX    = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SCAN, OFFER, BUSY} state_t;

  state_t         state, state_nxt;
  logic [GW-1:0]  ptr, ptr_nxt;
  logic [GW-1:0]  grant_num_nxt;
  logic [15:0]    tcnt, tcnt_nxt;
  logic [2:0]     err_nxt;
  logic [N_THREADS-1:0] elig;
  logic           found;
  logic [GW-1:0]  win;
  logic [PW-1:0]  idx;

  assign elig = req & slot_ready;

  // Search starts one past the last accepted thread and ends on ptr itself.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 1; i <= N_THREADS; i++) begin
      idx = {1'b0, ptr} + PW'(i);
      if (idx >= PW'(N_THREADS))
        idx = idx - PW'(N_THREADS);
      if (!found && elig[idx[GW-1:0]]) begin
        found = 1'b1;
        win   = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    grant_num_nxt = grant_num;
    tcnt_nxt      = tcnt;
    err_nxt       = err;

    if (done && state != BUSY)
      err_nxt[0] = 1'b1;

    case (state)
      IDLE: begin
        if (|elig)
          state_nxt = SCAN;
      end
      SCAN: begin
        if (found) begin
          grant_num_nxt = win;
          state_nxt     = OFFER;
        end else begin
          state_nxt = IDLE;
        end
      end
      OFFER: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (grant_ack) begin
          ptr_nxt   = grant_num;
          tcnt_nxt  = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        tcnt_nxt = (tcnt == TMAX) ? tcnt : tcnt + 16'd1;
        // done outranks both abort and the timeout terminal count
        if (done) begin
          if (done_num != grant_num)
            err_nxt[1] = 1'b1;
          state_nxt = IDLE;
        end else if (abort) begin
          state_nxt = IDLE;
        end else if (tcnt == TMAX - 16'd1) begin
          err_nxt[2] = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      ptr         <= PTR_RST;
      grant_num   <= '0;
      tcnt        <= '0;
      err         <= '0;
      grant_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant_num   <= grant_num_nxt;
      tcnt        <= tcnt_nxt;
      err         <= err_nxt;
      grant_valid <= (state_nxt == OFFER);
      busy        <= (state_nxt == BUSY);
    end
  end

endmodule

// File: tb/tb_thread_sched.sv
// Self-checking bench for thread_sched: directed corner cases then randomized traffic
// against a transaction-level round-robin model.
module tb_thread_sched;

  localparam int N  = 16;
  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] req, slot_ready;
  logic        grant_valid, grant_ack, done, abort, busy;
  logic [3:0]  grant_num, done_num;
  logic [2:0]  err;

  int          n_checks = 0;
  int          n_errs   = 0;
  int          m_ptr;
  logic [2:0]  m_err;

  thread_sched #(.N_THREADS(N), .N_THREADS_MSB(3), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .slot_ready(slot_ready),
    .grant_valid(grant_valid), .grant_num(grant_num), .grant_ack(grant_ack),
    .done(done), .done_num(done_num), .abort(abort), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference round-robin: first eligible thread strictly after p, wrapping back to p.
  function automatic int rr_pick(input int p, input logic [15:0] e);
    for (int k = 1; k <= N; k++) begin
      int t;
      t = (p + k) % N;
      if (e[t]) return t;
    end
    return -1;
  endfunction

  task automatic get_offer(input logic [15:0] r, input logic [15:0] s, output int win);
    int lat;
    req = r;
    slot_ready = s;
    win = rr_pick(m_ptr, r & s);
    lat = 0;
    while (!grant_valid && lat < 10) begin
      @(negedge CLK);
      lat++;
    end
    chk("offer_latency", lat, 2);
    chk("grant_num", {28'd0, grant_num}, win);
  endtask

  task automatic accept(input int win);
    grant_ack = 1'b1;
    @(negedge CLK);
    grant_ack = 1'b0;
    m_ptr = win;
    chk("busy_after_ack", busy, 1);
    chk("gv_after_ack", grant_valid, 0);
  endtask

  task automatic send_done(input logic [3:0] dn, input logic with_abort);
    done = 1'b1;
    done_num = dn;
    abort = with_abort;
    @(negedge CLK);
    done = 1'b0;
    abort = 1'b0;
    if (int'(dn) != m_ptr) m_err[1] = 1'b1;
    chk("busy_after_done", busy, 0);
    chk("err_after_done", err, m_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2, d, act;
    logic [15:0] r, s;

    RST_N = 1'b0; req = '0; slot_ready = '0; grant_ack = 1'b0;
    done = 1'b0; done_num = '0; abort = 1'b0;
    m_ptr = N - 1; m_err = '0;
    #1;
    chk("rst_gv", grant_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_gnum", grant_num, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // basic grant: thread 0 first after reset
    get_offer(16'h0001, 16'h0001, w);
    chk("first_grant_is_0", grant_num, 0);
    accept(w);
    req = '0;
    send_done(4'd0, 1'b0);

    // fairness with everything eligible
    for (int i = 0; i < 17; i++) begin
      get_offer(16'hFFFF, 16'hFFFF, w);
      chk("rr_seq", grant_num, (i + 1) % N);
      accept(w);
      send_done(4'(w), 1'b0);
    end

    // slot 5 not ready: it must be skipped
    for (int i = 0; i < 8; i++) begin
      get_offer(16'hFFFF, 16'hFFDF, w);
      chk("skip5", (grant_num == 4'd5), 0);
      accept(w);
      send_done(4'(w), 1'b0);
    end

    // wrap-around and ptr==winner
    get_offer(16'h8000, 16'hFFFF, w); accept(w); send_done(4'(w), 1'b0);
    get_offer(16'h8000, 16'hFFFF, w);
    chk("ptr_eq_winner", grant_num, 15);
    accept(w); send_done(4'(w), 1'b0);
    get_offer(16'h0008, 16'hFFFF, w);
    chk("wrap_to_3", grant_num, 3);
    accept(w); req = '0; send_done(4'(w), 1'b0);

    // protocol errors
    done = 1'b1; done_num = 4'd0;
    @(negedge CLK);
    done = 1'b0;
    m_err[0] = 1'b1;
    chk("err_idle_done", err, 3'b001);
    chk("idle_done_no_busy", busy, 0);
    get_offer(16'h0080, 16'hFFFF, w);
    accept(w);
    req = '0;
    send_done(4'd2, 1'b0);
    chk("err_mismatch", err, 3'b011);
    chk("mismatch_gv", grant_valid, 0);

    // timeout: err[2] exactly TO edges after the transfer
    get_offer(16'h0101, 16'hFFFF, w);
    accept(w);
    for (int i = 1; i <= TO; i++) begin
      @(negedge CLK);
      if (i < TO) begin
        chk("to_busy_hold", busy, 1);
        chk("to_err_clear", err[2], 0);
      end else begin
        m_err[2] = 1'b1;
        chk("to_busy_drop", busy, 0);
        chk("to_err_set", err, m_err);
      end
    end
    get_offer(16'h0101, 16'hFFFF, w2);
    chk("to_next_differs", (w2 != w), 1);
    accept(w2); send_done(4'(w2), 1'b0);

    // abort in OFFER: same thread re-offered, then abort in BUSY
    get_offer(16'h0410, 16'hFFFF, w);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("abort_offer_gv", grant_valid, 0);
    get_offer(16'h0410, 16'hFFFF, w2);
    chk("reoffer_same", w2, w);
    accept(w2);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_busy_err", err, m_err);

    // asynchronous reset mid-BUSY
    get_offer(16'hFFFF, 16'hFFFF, w);
    accept(w);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_gv", grant_valid, 0);
    chk("arst_err", err, 0);
    m_ptr = N - 1; m_err = '0;
    @(negedge CLK);
    RST_N = 1'b1;

    // done on the timeout terminal edge: done wins, no timeout error
    get_offer(16'hFFFF, 16'hFFFF, w);
    chk("post_rst_thread0", grant_num, 0);
    accept(w);
    repeat (TO - 1) @(negedge CLK);
    chk("done_to_still_busy", busy, 1);
    send_done(4'(w), 1'b0);
    chk("done_beats_timeout", err, 3'b000);

    // done with wrong num plus abort: done's check still applies
    get_offer(16'hFFFF, 16'hFFFF, w);
    accept(w);
    send_done(4'((w + 1) % N), 1'b1);
    chk("done_abort_err", err, 3'b010);

    // randomized traffic
    for (int it = 0; it < 120; it++) begin
      r = 16'($urandom);
      s = 16'($urandom) | 16'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      if ((r & s) == 16'd0) begin
        req = r; slot_ready = s;
        repeat (4) @(negedge CLK);
        chk("no_offer", grant_valid, 0);
        continue;
      end
      get_offer(r, s, w);
      act = int'($urandom_range(0, 9));
      if (act == 0) begin
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("rnd_abort_offer", grant_valid, 0);
        continue;
      end
      accept(w);
      d = int'($urandom_range(0, 5));
      repeat (d) @(negedge CLK);
      chk("rnd_busy_hold", busy, 1);
      if (act == 1) begin
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("rnd_abort_busy", busy, 0);
        chk("rnd_abort_err", err, m_err);
      end else if (act == 2) begin
        send_done(4'((w + 1) % N), 1'b0);
      end else begin
        send_done(4'(w), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
